// File: rtl/dpu_chain_feeder_if.sv
// Stream bundle between the chain feeder and its environment:
// weight load, sample input and result output, each a valid/ready handshake.
interface dpu_chain_feeder_if #(
    parameter int DW = 32
);
    logic [DW-1:0]        w_data;
    logic                 w_valid;
    logic                 w_ready;
    logic signed [DW-1:0] s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic signed [DW-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;

    modport master (
        output w_data, w_valid, s_data, s_valid, s_last, m_ready,
        input  w_ready, s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  w_data, w_valid, s_data, s_valid, s_last, m_ready,
        output w_ready, s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/dpu_chain_feeder.sv
// Feeds one systolic dpu chain: loads the weight bank, streams samples under a
// credit limit, and drains chain results through a first-word-fall-through FIFO.
module dpu_chain_feeder #(
    parameter int DW        = 32,
    parameter int TAPS      = 4,
    parameter int CHAIN_LAT = 9,
    parameter int OUT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dpu_chain_feeder_if.slave    bus,
    output logic [TAPS*DW-1:0]   chain_w,
    output logic signed [DW-1:0] chain_xin,
    output logic signed [DW-1:0] chain_yin,
    input  logic signed [DW-1:0] chain_yout,
    output logic                 busy,
    output logic                 done
);
    localparam int WW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int IW = $clog2(CHAIN_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [WW-1:0]        widx;
    logic                 w_ready, s_ready, w_acc, s_acc;
    logic                 credit_ok;
    logic [CHAIN_LAT-1:0] tag_vld_p, tag_last_p;
    logic [IW-1:0]        inflight;
    logic signed [DW-1:0] fifo_data [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] fifo_last;
    logic [PW-1:0]        wptr, rptr;
    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_wr, fifo_rd, m_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A sample is only admitted if its result is guaranteed a FIFO slot.
    assign credit_ok = (32'(inflight) + 32'(fifo_cnt)) < 32'(OUT_DEPTH);
    assign w_acc     = bus.w_valid & w_ready;
    assign s_acc     = bus.s_valid & s_ready;

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        s_ready   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.w_valid) state_nxt = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                if (bus.w_valid && widx == WW'(TAPS - 1)) state_nxt = RUN;
            end
            RUN: begin
                s_ready = credit_ok;
                if (bus.s_valid && credit_ok && bus.s_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0 && fifo_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_w <= '0;
            widx    <= '0;
        end else if (w_acc) begin
            chain_w[widx*DW +: DW] <= bus.w_data;
            widx <= (widx == WW'(TAPS - 1)) ? '0 : widx + WW'(1);
        end
    end

    // Stage p0: chain head register and tag entry; tags then ride alongside the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_xin  <= '0;
            tag_vld_p  <= '0;
            tag_last_p <= '0;
            inflight   <= '0;
        end else begin
            chain_xin  <= s_acc ? bus.s_data : '0;
            tag_vld_p  <= (tag_vld_p << 1) | CHAIN_LAT'(s_acc);
            tag_last_p <= (tag_last_p << 1) | CHAIN_LAT'(s_acc & bus.s_last);
            case ({s_acc, tag_vld_p[CHAIN_LAT-1]})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: ;
            endcase
        end
    end

    assign chain_yin = '0;

    // Chain tail: a valid tag at the last stage captures chain_yout into the FIFO.
    assign fifo_wr = tag_vld_p[CHAIN_LAT-1];
    assign fifo_rd = m_valid & bus.m_ready;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wptr] <= chain_yout;
            fifo_last[wptr] <= tag_last_p[CHAIN_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wptr <= ptr_inc(wptr);
            if (fifo_rd) rptr <= ptr_inc(rptr);
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    assign m_valid     = (fifo_cnt != '0);
    assign bus.m_valid = m_valid;
    assign bus.m_data  = fifo_data[rptr];
    assign bus.m_last  = m_valid & fifo_last[rptr];
    assign bus.w_ready = w_ready;
    assign bus.s_ready = s_ready;
    assign busy        = (state != IDLE);
endmodule
